// File: rtl/can_tx_framer.sv
// CAN 2.0A/2.0B frame transmitter: serialises one frame bit per sample_point, with bit
// stuffing, CRC-15, read-back arbitration-loss detection and ACK-slot checking.
module can_tx_framer #(
  parameter int MAX_BYTES = 8,
  parameter int EXT_ID_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_point,
  input  logic                   start_tx,
  input  logic                   ide,
  input  logic                   rtr,
  input  logic [28:0]            id,
  input  logic [3:0]             dlc,
  input  logic [MAX_BYTES*8-1:0] tx_data,
  input  logic                   rx_bit,
  output logic                   tx_bit,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   arb_lost,
  output logic                   ack_err,
  output logic [14:0]            crc_out,
  output logic                   crc_active,
  output logic                   arbitration_active
);

  localparam logic [3:0] MaxB = 4'(MAX_BYTES);

  // ST_WAIT: request accepted, SOF goes out on the next sample_point
  typedef enum logic [4:0] {
    ST_IDLE, ST_WAIT, ST_SOF, ST_ID_A, ST_SRR, ST_IDE, ST_ID_B, ST_RTR, ST_R1, ST_R0,
    ST_DLC, ST_DATA, ST_CRC, ST_CRC_DEL, ST_ACK_SLOT, ST_ACK_DEL, ST_EOF, ST_IFS
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [2:0]  same_cnt_q, same_cnt_d;
  logic [14:0] crc_q, crc_d;
  logic        tx_bit_q, tx_bit_d;
  logic        busy_q, busy_d;
  logic        tx_done_q, tx_done_d;
  logic        arb_lost_q, arb_lost_d;
  logic        ack_err_q, ack_err_d;
  logic        crc_active_q, crc_active_d;
  logic        arb_active_q, arb_active_d;

  logic [28:0]            id_q;
  logic                   ext_q;
  logic                   rtr_q;
  logic [3:0]             dlc_q;
  logic [MAX_BYTES*8-1:0] data_q;
  logic [6:0]             data_bits_q;

  logic        load_s;
  logic [3:0]  dlc_eff_s;
  logic [63:0] data_pad_s;
  logic [10:0] id_base_s;
  state_t      adv_state_s;
  logic [6:0]  adv_idx_s;
  logic        nxt_bit_s;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  function automatic logic [6:0] field_last(input state_t s, input logic [6:0] data_bits);
    case (s)
      ST_ID_A: return 7'd10;
      ST_ID_B: return 7'd17;
      ST_DLC:  return 7'd3;
      ST_DATA: return data_bits - 7'd1;
      ST_CRC:  return 7'd14;
      ST_EOF:  return 7'd6;
      ST_IFS:  return 7'd2;
      default: return 7'd0;
    endcase
  endfunction

  function automatic state_t next_field(input state_t s, input logic ext, input logic has_data);
    case (s)
      ST_SOF:      return ST_ID_A;
      ST_ID_A:     return ext ? ST_SRR : ST_RTR;
      ST_SRR:      return ST_IDE;
      ST_IDE:      return ext ? ST_ID_B : ST_R0;
      ST_ID_B:     return ST_RTR;
      ST_RTR:      return ext ? ST_R1 : ST_IDE;
      ST_R1:       return ST_R0;
      ST_R0:       return ST_DLC;
      ST_DLC:      return has_data ? ST_DATA : ST_CRC;
      ST_DATA:     return ST_CRC;
      ST_CRC:      return ST_CRC_DEL;
      ST_CRC_DEL:  return ST_ACK_SLOT;
      ST_ACK_SLOT: return ST_ACK_DEL;
      ST_ACK_DEL:  return ST_EOF;
      ST_EOF:      return ST_IFS;
      default:     return ST_IDLE;
    endcase
  endfunction

  // IDE belongs to the arbitration field only in extended frames
  function automatic logic in_arb(input state_t s, input logic ext);
    case (s)
      ST_ID_A, ST_SRR, ST_ID_B, ST_RTR: return 1'b1;
      ST_IDE:  return ext;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic in_crc(input state_t s);
    return (s >= ST_SOF) && (s <= ST_DATA);
  endfunction

  function automatic logic in_stuff(input state_t s);
    return (s >= ST_SOF) && (s <= ST_CRC);
  endfunction

  assign dlc_eff_s  = (dlc > MaxB) ? MaxB : dlc;
  assign data_pad_s = 64'(data_q);
  assign id_base_s  = ext_q ? id_q[28:18] : id_q[10:0];

  // Position of the next non-stuff bit after the last one sent
  always_comb begin
    adv_state_s = state_q;
    adv_idx_s   = idx_q;
    if (idx_q == field_last(state_q, data_bits_q)) begin
      adv_state_s = next_field(state_q, ext_q, data_bits_q != 7'd0);
      adv_idx_s   = 7'd0;
    end else begin
      adv_state_s = state_q;
      adv_idx_s   = idx_q + 7'd1;
    end
  end

  // Value of the bit at that position
  always_comb begin
    nxt_bit_s = 1'b1;
    case (adv_state_s)
      ST_SOF:  nxt_bit_s = 1'b0;
      ST_ID_A: nxt_bit_s = id_base_s[4'd10 - adv_idx_s[3:0]];
      ST_SRR:  nxt_bit_s = 1'b1;
      ST_IDE:  nxt_bit_s = ext_q;
      ST_ID_B: nxt_bit_s = id_q[5'd17 - adv_idx_s[4:0]];
      ST_RTR:  nxt_bit_s = rtr_q;
      ST_R1:   nxt_bit_s = 1'b0;
      ST_R0:   nxt_bit_s = 1'b0;
      ST_DLC:  nxt_bit_s = dlc_q[2'd3 - adv_idx_s[1:0]];
      ST_DATA: nxt_bit_s = data_pad_s[{adv_idx_s[5:3], ~adv_idx_s[2:0]}];
      ST_CRC:  nxt_bit_s = crc_q[4'd14 - adv_idx_s[3:0]];
      default: nxt_bit_s = 1'b1;
    endcase
  end

  // Next-state and output logic: check the bit on the bus, then choose the next one
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    same_cnt_d   = same_cnt_q;
    crc_d        = crc_q;
    tx_bit_d     = tx_bit_q;
    busy_d       = busy_q;
    tx_done_d    = 1'b0;
    arb_lost_d   = 1'b0;
    ack_err_d    = 1'b0;
    crc_active_d = crc_active_q;
    arb_active_d = arb_active_q;
    load_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_tx) begin
          load_s     = 1'b1;
          state_d    = ST_WAIT;
          idx_d      = 7'd0;
          same_cnt_d = 3'd0;
          crc_d      = 15'h0000;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (sample_point) begin
          state_d      = ST_SOF;
          idx_d        = 7'd0;
          tx_bit_d     = 1'b0;
          same_cnt_d   = 3'd1;
          crc_d        = crc15_step(crc_q, 1'b0);
          crc_active_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        if (sample_point) begin
          if (arb_active_q && tx_bit_q && !rx_bit) begin
            arb_lost_d   = 1'b1;
            tx_bit_d     = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
            idx_d        = 7'd0;
            crc_active_d = 1'b0;
            arb_active_d = 1'b0;
          end else begin
            ack_err_d = (state_q == ST_ACK_SLOT) && rx_bit;
            if (in_stuff(state_q) && (same_cnt_q == 3'd5)) begin
              // stuff bit: position and CRC stay put
              tx_bit_d   = ~tx_bit_q;
              same_cnt_d = 3'd1;
            end else if (adv_state_s == ST_IDLE) begin
              tx_done_d    = 1'b1;
              busy_d       = 1'b0;
              tx_bit_d     = 1'b1;
              state_d      = ST_IDLE;
              idx_d        = 7'd0;
              crc_active_d = 1'b0;
              arb_active_d = 1'b0;
            end else begin
              state_d      = adv_state_s;
              idx_d        = adv_idx_s;
              tx_bit_d     = nxt_bit_s;
              same_cnt_d   = (nxt_bit_s != tx_bit_q) ? 3'd1 :
                             ((same_cnt_q == 3'd7) ? 3'd7 : same_cnt_q + 3'd1);
              crc_active_d = in_crc(adv_state_s);
              arb_active_d = in_arb(adv_state_s, ext_q);
              if (in_crc(adv_state_s)) begin
                crc_d = crc15_step(crc_q, nxt_bit_s);
              end else begin
                crc_d = crc_q;
              end
            end
          end
        end else begin
          state_d = state_q;
        end
      end
    endcase
  end

  // Frame state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 7'd0;
      same_cnt_q   <= 3'd0;
      crc_q        <= 15'h0000;
      tx_bit_q     <= 1'b1;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
      arb_lost_q   <= 1'b0;
      ack_err_q    <= 1'b0;
      crc_active_q <= 1'b0;
      arb_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      same_cnt_q   <= same_cnt_d;
      crc_q        <= crc_d;
      tx_bit_q     <= tx_bit_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
      arb_lost_q   <= arb_lost_d;
      ack_err_q    <= ack_err_d;
      crc_active_q <= crc_active_d;
      arb_active_q <= arb_active_d;
    end
  end

  // Frame contents captured when a request is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q        <= 29'h0;
      ext_q       <= 1'b0;
      rtr_q       <= 1'b0;
      dlc_q       <= 4'h0;
      data_q      <= '0;
      data_bits_q <= 7'd0;
    end else if (load_s) begin
      id_q        <= id;
      ext_q       <= (EXT_ID_EN != 0) ? ide : 1'b0;
      rtr_q       <= rtr;
      dlc_q       <= dlc;
      data_q      <= tx_data;
      data_bits_q <= rtr ? 7'd0 : {dlc_eff_s, 3'b000};
    end
  end

  assign tx_bit             = tx_bit_q;
  assign busy               = busy_q;
  assign tx_done            = tx_done_q;
  assign arb_lost           = arb_lost_q;
  assign ack_err            = ack_err_q;
  assign crc_out            = crc_q;
  assign crc_active         = crc_active_q;
  assign arbitration_active = arb_active_q;

endmodule

// File: doc/can_tx_framer.md
Name: can_tx_framer

Overview:
Parametrised CAN 2.0A/2.0B frame transmitter. It replaces the fixed-format transmitter and CRC pair with a single block that adds several features:
- standard or extended identifiers
- DLC-driven data length up to MAX_BYTES
- remote frames
- bit stuffing
- bus read-back arbitration-loss detection and ACK checking

It sits between the host TX buffer and the bit-timing unit. The bit-timing unit supplies sample_point.

Parameters:
MAX_BYTES, 8, maximum data bytes per frame (1..8); larger DLC values are clamped to this.
EXT_ID_EN, 1, 1 = extended (29-bit) frames supported; 0 = the ide input is ignored and treated as 0.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
sample_point  input  1  one-cycle bit-time strobe; all frame progress happens only on clk edges where this is 1
start_tx  input  1  request to transmit; accepted only in IDLE
ide  input  1  1 = extended frame
rtr  input  1  1 = remote frame (no data field)
id  input  29  identifier; standard frames use id[10:0], extended frames use id[28:18] as base and id[17:0] as extension
dlc  input  4  data length code
tx_data  input  MAX_BYTES*8  byte k = tx_data[8k+7:8k]; bytes sent byte 0 first, each MSB first
rx_bit  input  1  bus read-back value, valid at sample_point
tx_bit  output  1  bus drive bit (0 = dominant)
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of IFS
arb_lost  output  1  one-cycle pulse on arbitration loss
ack_err  output  1  one-cycle pulse when the ACK slot is read recessive
crc_out  output  15  running/final CRC-15
crc_active  output  1  high while bits SOF..last data bit are sent
arbitration_active  output  1  high during the arbitration field

Behaviour:
Clocking and reset:
- One clock; reset is asynchronous and active-high.
- Reset values: tx_bit=1, busy=0, tx_done=0, arb_lost=0, ack_err=0, crc_out=0, crc_active=0, arbitration_active=0, state=IDLE.

Frame start:
- In IDLE, start_tx=1 latches id, ide, rtr, dlc and tx_data, clears the CRC and stuff counters, and sets busy=1 on the next edge.
- At the next sample_point, tx_bit=0 (SOF).
- start_tx is ignored while busy.

Bit timing:
- On each sample_point edge, the block first checks rx_bit against the bit currently driven, then drives the next bit.
- tx_bit is registered and changes only on sample_point edges.

State machine (bits per state in brackets):
- Common prefix: IDLE -> SOF[1] -> ID_A[11].
- Standard frame: ID_A -> RTR[1] -> IDE[1]=0 -> R0[1]=0 -> DLC[4].
- Extended frame: ID_A -> SRR[1]=1 -> IDE[1]=1 -> ID_B[18] -> RTR[1] -> R1[1]=0 -> R0[1]=0 -> DLC[4].
- Common tail: DLC -> DATA[8*n] -> CRC[15] -> CRC_DEL[1]=1 -> ACK_SLOT[1]=1 -> ACK_DEL[1]=1 -> EOF[7]=1 -> IFS[3]=1 -> IDLE.
- DATA is skipped when n=0.

Data length:
- n = 0 if rtr=1; otherwise n = min(dlc, MAX_BYTES).
- The DLC field transmits the latched dlc unmodified.

CRC:
- CRC-15, polynomial 0x4599, init 0.
- Updated with each non-stuff bit from SOF through the last DATA (or DLC) bit.
- Frozen afterwards; the CRC field sends crc_out MSB first.

Bit stuffing:
- Applies from SOF through the last CRC bit.
- After 5 consecutive identical transmitted bits (stuff bits included in the count), one complement bit is inserted.
- The inserted stuff bit restarts the count at 1.
- No stuffing from CRC_DEL onward.
- Stuff bits do not advance field counters and do not enter the CRC.

Arbitration:
- arbitration_active=1 from ID_A through RTR inclusive.
- In that window, if tx_bit=1 and rx_bit=0 at sample_point: pulse arb_lost, set tx_bit=1, busy=0, go to IDLE. No tx_done pulse.
- A dominant mismatch outside the window is ignored (error handling lives elsewhere).

ACK:
- In ACK_SLOT, rx_bit=1 pulses ack_err.
- The frame still completes, and tx_done still pulses.

Other boundaries:
- rst asserted mid-frame returns all outputs to reset values immediately, with no pulses.
- A sample_point on the same edge as start_tx in IDLE only accepts the request; SOF is driven at the following sample_point.

Test Plan:
1. Standard frame, id=0x123, dlc=1, tx_data[7:0]=0xAA, rx_bit mirrors tx_bit -> SOF + 11 ID bits 00100100011, RTR/IDE/R0=0, DLC=0001, data 10101010; crc_out matches the golden CRC-15 model; tx_done one cycle after the third IFS bit.
2. Standard frame, id=0x000, dlc=0, rtr=0 -> stuff bit 1 inserted immediately after ID bit 7 (SOF+ID10..ID7 = five zeros); further stuff bits every 5 identical bits; CRC excludes all stuff bits.
3. Extended frame, ide=1, id=0x1ABCDE01, dlc=15, MAX_BYTES=8 -> SRR=1, IDE=1, 18 extension bits, DLC sent as 1111, exactly 64 data bits.
4. Arbitration loss: standard id=0x7FF, force rx_bit=0 on the 3rd ID bit -> arb_lost pulse, tx_bit=1 thereafter, busy=0, no tx_done; a new start_tx is accepted afterwards.
5. ACK missing: rx_bit=1 during ACK_SLOT -> ack_err single pulse, frame completes, tx_done pulses.
6. Reset and busy: rst asserted during DATA -> tx_bit=1, busy=0 within the same cycle, no pulses; separately, start_tx during busy -> ignored and the frame is unchanged.
